// File: rtl/pit_counter_channel.sv
// -----------------------------------------------------------------------------
// pit_counter_channel
// One channel of a programmable interval timer supporting mode 0 (interrupt
// on terminal count), mode 2 (rate generator) and mode 3 (square wave).
//
// Ports
//   clk         system clock, all state updates on its rising edge
//   reset       asynchronous active-high reset
//   tick        count-clock enable, one count event per asserted cycle
//   gate        level gate; rising edge detected internally (modes 2/3 reload)
//   ctrl_wr     control-word write strobe, ctrl_mode selects the mode
//   ctrl_mode   00 = mode 0, 01 = mode 2, 10 = mode 3, 11 = reserved (ignored)
//   cnt_wr      count write strobe, cnt_data is the new initial count
//   cnt_data    initial count (0 stands for 2^WIDTH)
//   latch       snapshot the counting element into the read latch
//   rd          read acknowledge, releases the read latch
//   rd_data     latched value while held, otherwise the live counting element
//   out         timer output (registered)
//   null_count  high while a written count has not reached the counting element
// -----------------------------------------------------------------------------
module pit_counter_channel #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             gate,
    input  logic             ctrl_wr,
    input  logic [1:0]       ctrl_mode,
    input  logic             cnt_wr,
    input  logic [WIDTH-1:0] cnt_data,
    input  logic             latch,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             out,
    output logic             null_count
);

    localparam logic [1:0] MODE_0    = 2'b00;
    localparam logic [1:0] MODE_2    = 2'b01;
    localparam logic [1:0] MODE_3    = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no count written since the last control word
        ST_LOAD  = 2'd1,   // count written, waiting for the transfer tick
        ST_COUNT = 2'd2    // counting element is running
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       mode_reg, mode_next;
    logic [WIDTH-1:0] ce_reg, ce_next;
    logic [WIDTH-1:0] cr_reg, cr_next;
    logic [WIDTH-1:0] latch_reg, latch_next;
    logic             held_reg, held_next;
    logic             out_reg, out_next;
    logic             null_reg, null_next;
    logic             gate_reg;

    // Effective period in WIDTH+1 bits: 0 means 2^WIDTH and the illegal
    // period 1 is promoted to 2 for the periodic modes.
    logic [WIDTH:0]   n_eff;
    logic [WIDTH-1:0] half_hi;    // ceil(n/2): high half of mode 3
    logic [WIDTH-1:0] half_lo;    // floor(n/2): low half of mode 3
    logic [WIDTH-1:0] reload_m2;  // mode 2 reload value
    logic [WIDTH-1:0] load_val;
    logic             gate_rise;
    logic             ctrl_ok;

    always_comb begin
        if (cr_reg == '0) begin
            n_eff = {1'b1, {WIDTH{1'b0}}};
        end else if (cr_reg == ONE) begin
            n_eff = {1'b0, TWO};
        end else begin
            n_eff = {1'b0, cr_reg};
        end
        half_lo   = n_eff[WIDTH:1];
        half_hi   = n_eff[WIDTH:1] + {{(WIDTH-1){1'b0}}, n_eff[0]};
        reload_m2 = n_eff[WIDTH-1:0];
        case (mode_reg)
            MODE_2:  load_val = reload_m2;
            MODE_3:  load_val = half_hi;
            default: load_val = cr_reg;
        endcase
    end

    assign gate_rise = gate & ~gate_reg;
    assign ctrl_ok   = ctrl_wr && (ctrl_mode != MODE_RSVD);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            mode_reg  <= MODE_0;
            ce_reg    <= '0;
            cr_reg    <= '0;
            latch_reg <= '0;
            held_reg  <= 1'b0;
            out_reg   <= 1'b0;
            null_reg  <= 1'b1;
            gate_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            ce_reg    <= ce_next;
            cr_reg    <= cr_next;
            latch_reg <= latch_next;
            held_reg  <= held_next;
            out_reg   <= out_next;
            null_reg  <= null_next;
            gate_reg  <= gate;
        end
    end

    // Next-state logic. The tick is evaluated against the current state first;
    // a coincident count write is then overlaid so it wins on CR, null_count
    // and (mode 0) out, and the transfer of the new count waits for a later tick.
    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        ce_next    = ce_reg;
        cr_next    = cr_reg;
        latch_next = latch_reg;
        held_next  = held_reg;
        out_next   = out_reg;
        null_next  = null_reg;

        if (ctrl_ok) begin
            mode_next  = ctrl_mode;
            state_next = ST_IDLE;
            null_next  = 1'b1;
            held_next  = 1'b0;
            out_next   = (ctrl_mode != MODE_0);
        end else begin
            // A latch coincident with rd re-arms with a fresh snapshot.
            if (latch && (!held_reg || rd)) begin
                latch_next = ce_reg;
                held_next  = 1'b1;
            end else if (rd) begin
                held_next = 1'b0;
            end

            if ((mode_reg != MODE_0) && (state_reg == ST_COUNT) && gate_rise) begin
                // Retrigger: the next tick reloads from CR.
                state_next = ST_LOAD;
            end else if (tick) begin
                if (state_reg == ST_LOAD) begin
                    // Transfer tick: no decrement.
                    ce_next    = load_val;
                    state_next = ST_COUNT;
                    null_next  = 1'b0;
                    if (mode_reg != MODE_0) begin
                        out_next = 1'b1;
                    end
                end else if ((state_reg == ST_COUNT) && gate) begin
                    case (mode_reg)
                        MODE_0: begin
                            if (ce_reg == ONE) begin
                                out_next = 1'b1;
                            end
                            ce_next = ce_reg - ONE;
                        end
                        MODE_2: begin
                            if (ce_reg == TWO) begin
                                ce_next  = ONE;
                                out_next = 1'b0;
                            end else if (ce_reg == ONE) begin
                                ce_next   = reload_m2;
                                out_next  = 1'b1;
                                null_next = 1'b0;
                            end else begin
                                ce_next = ce_reg - ONE;
                            end
                        end
                        MODE_3: begin
                            // CE counts ticks remaining in the current half;
                            // each half boundary reloads from CR.
                            if (ce_reg == ONE) begin
                                null_next = 1'b0;
                                if (out_reg) begin
                                    out_next = 1'b0;
                                    ce_next  = half_lo;
                                end else begin
                                    out_next = 1'b1;
                                    ce_next  = half_hi;
                                end
                            end else begin
                                ce_next = ce_reg - ONE;
                            end
                        end
                        default: ce_next = ce_reg;
                    endcase
                end
            end

            if ((mode_reg != MODE_0) && !gate) begin
                out_next = 1'b1;
            end

            if (cnt_wr) begin
                cr_next   = cnt_data;
                null_next = 1'b1;
                if (mode_reg == MODE_0) begin
                    out_next   = 1'b0;
                    state_next = ST_LOAD;
                end else if (state_reg == ST_IDLE) begin
                    state_next = ST_LOAD;
                end
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        rd_data    = held_reg ? latch_reg : ce_reg;
        out        = out_reg;
        null_count = null_reg;
    end

endmodule

// File: tb/tb_pit_counter_channel.sv
// -----------------------------------------------------------------------------
// tb_pit_counter_channel
// Self-checking bench for pit_counter_channel (WIDTH = 4). Directed sequences
// check literal expected waveforms; every cycle the outputs are also compared
// with a behavioural model, which then drives a randomized phase.
// -----------------------------------------------------------------------------
module tb_pit_counter_channel;

    localparam int W    = 4;
    localparam int MASK = 15;

    logic         clk = 1'b0;
    logic         reset;
    logic         tick;
    logic         gate;
    logic         ctrl_wr;
    logic [1:0]   ctrl_mode;
    logic         cnt_wr;
    logic [W-1:0] cnt_data;
    logic         latch;
    logic         rd;
    logic [W-1:0] rd_data;
    logic         out;
    logic         null_count;

    always #5 clk = ~clk;

    pit_counter_channel #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .gate       (gate),
        .ctrl_wr    (ctrl_wr),
        .ctrl_mode  (ctrl_mode),
        .cnt_wr     (cnt_wr),
        .cnt_data   (cnt_data),
        .latch      (latch),
        .rd         (rd),
        .rd_data    (rd_data),
        .out        (out),
        .null_count (null_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_cyc    = 0;
    bit gate_lvl = 1'b1;

    // Reference model: mode is 0/2/3, phase 0 = idle, 1 = awaiting transfer,
    // 2 = counting. In mode 3 m_ce is the number of ticks left in the half.
    int m_mode, m_st, m_ce, m_cr, m_latch, m_held, m_out, m_null, m_gprev;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, n_cyc);
        end
    endtask

    function automatic int m_n();
        if (m_cr == 0) return 16;
        if (m_cr == 1) return 2;
        return m_cr;
    endfunction

    function automatic int m_load();
        if (m_mode == 2) return m_n() & MASK;
        if (m_mode == 3) return (m_n() + 1) / 2;
        return m_cr;
    endfunction

    function automatic int m_rd();
        return m_held ? m_latch : m_ce;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_st = 0; m_ce = 0; m_cr = 0; m_latch = 0;
        m_held = 0; m_out = 0; m_null = 1; m_gprev = 0;
    endtask

    task automatic model_step(input bit t, input bit g, input bit cw, input logic [1:0] cm,
                              input bit nw, input int cd, input bit l, input bit r);
        bit rise;
        rise    = g && !m_gprev;
        m_gprev = g;
        if (cw && cm != 2'b11) begin
            m_mode = (cm == 2'b00) ? 0 : (cm == 2'b01) ? 2 : 3;
            m_st = 0; m_null = 1; m_held = 0;
            m_out = (m_mode == 0) ? 0 : 1;
        end else begin
            if (l && (!m_held || r)) begin
                m_latch = m_ce; m_held = 1;
            end else if (r) begin
                m_held = 0;
            end
            if (m_mode != 0 && m_st == 2 && rise) begin
                m_st = 1;
            end else if (t) begin
                if (m_st == 1) begin
                    m_ce = m_load(); m_st = 2; m_null = 0;
                    if (m_mode != 0) m_out = 1;
                end else if (m_st == 2 && g) begin
                    if (m_mode == 0) begin
                        if (m_ce == 1) m_out = 1;
                        m_ce = (m_ce - 1) & MASK;
                    end else if (m_mode == 2) begin
                        if (m_ce == 2) begin
                            m_ce = 1; m_out = 0;
                        end else if (m_ce == 1) begin
                            m_ce = m_n() & MASK; m_out = 1; m_null = 0;
                        end else begin
                            m_ce = (m_ce - 1) & MASK;
                        end
                    end else begin
                        if (m_ce == 1) begin
                            m_null = 0;
                            if (m_out == 1) begin
                                m_out = 0; m_ce = m_n() / 2;
                            end else begin
                                m_out = 1; m_ce = (m_n() + 1) / 2;
                            end
                        end else begin
                            m_ce = (m_ce - 1) & MASK;
                        end
                    end
                end
            end
            if (m_mode != 0 && !g) m_out = 1;
            if (nw) begin
                m_cr = cd; m_null = 1;
                if (m_mode == 0) begin
                    m_out = 0; m_st = 1;
                end else if (m_st == 0) begin
                    m_st = 1;
                end
            end
        end
    endtask

    // One clock cycle: drive, advance model at the edge, sample #1 later.
    task automatic cycle(input bit t, input bit cw, input logic [1:0] cm, input bit nw,
                         input logic [W-1:0] cd, input bit l, input bit r);
        tick = t; ctrl_wr = cw; ctrl_mode = cm; cnt_wr = nw;
        cnt_data = cd; latch = l; rd = r; gate = gate_lvl;
        @(posedge clk);
        model_step(t, gate_lvl, cw, cm, nw, int'(cd), l, r);
        #1;
        n_cyc++;
        $display("cyc %0d tick=%0b gate=%0b cw=%0b mode=%0d cnt_wr=%0b data=%0d latch=%0b rd=%0b -> out=%0b null=%0b rd_data=%0d",
                 n_cyc, t, gate_lvl, cw, cm, nw, cd, l, r, out, null_count, rd_data);
        check("model_out", out, m_out);
        check("model_null", null_count, m_null);
        check("model_rd_data", rd_data, m_rd());
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_tick();
        cycle(1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic set_mode(input logic [1:0] m);
        cycle(1'b0, 1'b1, m, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic write_cnt(input logic [W-1:0] d);
        cycle(1'b0, 1'b0, 2'b00, 1'b1, d, 1'b0, 1'b0);
    endtask

    initial begin
        int exp3 [10] = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        reset = 1'b1; tick = 0; gate = 1; ctrl_wr = 0; ctrl_mode = 0;
        cnt_wr = 0; cnt_data = 0; latch = 0; rd = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out, 0);
        check("reset_null", null_count, 1);
        check("reset_rd_data", rd_data, 0);
        reset = 1'b0;

        // Mode 0, count 5: out low through tick 5, rises on tick 6 and stays.
        set_mode(2'b00);
        check("m0_ctrl_out", out, 0);
        write_cnt(4'd5);
        check("m0_cnt_null", null_count, 1);
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            check($sformatf("m0_out_t%0d", k), out, (k >= 6) ? 1 : 0);
            if (k == 1) check("m0_null_after_load", null_count, 0);
            if (k == 6) check("m0_ce_tc", rd_data, 0);
            if (k == 7) check("m0_ce_wrap", rd_data, 15);
        end

        // Mode 2, N = 4: 1,1,1,0 repeating.
        set_mode(2'b01);
        check("m2_ctrl_out", out, 1);
        write_cnt(4'd4);
        for (int k = 1; k <= 12; k++) begin
            do_tick();
            check($sformatf("m2_out_t%0d", k), out, (k % 4 == 0) ? 0 : 1);
            if (k == 1) check("m2_null_after_load", null_count, 0);
        end

        // Mode 3, N = 5 then N = 4, then a mid-period rewrite to 6.
        set_mode(2'b10);
        write_cnt(4'd5);
        for (int k = 1; k <= 10; k++) begin
            do_tick();
            check($sformatf("m3n5_out_t%0d", k), out, (((k - 1) % 5) < 3) ? 1 : 0);
        end
        set_mode(2'b10);
        write_cnt(4'd4);
        for (int k = 1; k <= 5; k++) begin
            do_tick();
            check($sformatf("m3n4_out_t%0d", k), out, (((k - 1) % 4) < 2) ? 1 : 0);
        end
        write_cnt(4'd6);
        check("m3_rewrite_null", null_count, 1);
        for (int k = 6; k <= 15; k++) begin
            do_tick();
            check($sformatf("m3n6_out_t%0d", k), out, exp3[k - 6]);
            if (k == 7) check("m3_null_after_reload", null_count, 0);
        end

        // Mode 0 gate hold and latch/read.
        set_mode(2'b00);
        write_cnt(4'd10);
        for (int k = 0; k < 4; k++) do_tick();
        check("gate_pre_ce", rd_data, 7);
        gate_lvl = 1'b0;
        for (int k = 0; k < 4; k++) begin
            do_tick();
            check("gate_hold_ce", rd_data, 7);
        end
        gate_lvl = 1'b1;
        cycle(1'b0, 1'b0, 2'b00, 1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            do_tick();
            check("latched_rd_data", rd_data, 7);
        end
        cycle(1'b0, 1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b1);
        check("rd_released_live", rd_data, 4);

        // Control and count write together: count ignored, channel idle.
        cycle(1'b0, 1'b1, 2'b00, 1'b1, 4'd3, 1'b0, 1'b0);
        check("cw_cnt_null", null_count, 1);
        for (int k = 0; k < 3; k++) do_tick();
        check("cw_cnt_idle_ce", rd_data, 4);
        check("cw_cnt_idle_null", null_count, 1);
        // Count 0 means 16: out rises on tick 17.
        write_cnt(4'd0);
        for (int k = 1; k <= 17; k++) begin
            do_tick();
            check($sformatf("m0_full_out_t%0d", k), out, (k == 17) ? 1 : 0);
        end

        // Tick coincident with count write acts on the old count.
        cycle(1'b1, 1'b0, 2'b00, 1'b1, 4'd3, 1'b0, 1'b0);
        check("coinc_ce", rd_data, 15);
        check("coinc_out", out, 0);
        check("coinc_null", null_count, 1);
        do_tick();
        check("coinc_reload_ce", rd_data, 3);

        // Asynchronous reset mid-count in mode 2.
        set_mode(2'b01);
        write_cnt(4'd7);
        for (int k = 0; k < 3; k++) do_tick();
        check("pre_reset_ce", rd_data, 5);
        #2 reset = 1'b1;
        #1;
        check("async_reset_out", out, 0);
        check("async_reset_rd_data", rd_data, 0);
        check("async_reset_null", null_count, 1);
        #1 reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) do_tick();
        check("post_reset_no_count", rd_data, 0);

        // Randomized phase against the model.
        for (int i = 0; i < 1500; i++) begin
            if (gate_lvl && $urandom_range(0, 29) == 0) gate_lvl = 1'b0;
            else if (!gate_lvl && $urandom_range(0, 4) == 0) gate_lvl = 1'b1;
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 49) == 0),
                  2'($urandom_range(0, 3)),
                  ($urandom_range(0, 24) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 19) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
